icache_sa: RTL and testbench
============================

// Module: icache_sa
// PURPOSE
//  Parametrised set-associative instruction cache between the PC/fetch stage and the memory refill port.
//  Generalises the direct-mapped iCache in several ways:
//   - configurable sets, ways and line width;
//   - per-set round-robin replacement;
//   - explicit miss FSM with a fetch stall;
//   - deferred flush.
//  Sits in the fetch stage; the memory side uses a held request/ready handshake.
// PARAMETERS
//  ADDR_WIDTH   32   fetch address width (byte address)
//  INSTR_WIDTH  32   instruction width; LINE_WIDTH must be a multiple of it
//  LINE_WIDTH   128  cache line width in bits
//  NSETS        4    number of sets, power of two, >= 2
//  NWAYS        2    associativity, power of two, >= 1
//  Derived values:
//   OFF_W = log2(LINE_WIDTH/8)
//   IDX_W = log2(NSETS)
//   TAG_W = ADDR_WIDTH-IDX_W-OFF_W
//   WSEL_W = log2(LINE_WIDTH/INSTR_WIDTH)
// PORTS
//  clk        in   1               clock, rising edge
//  reset      in   1               asynchronous, active-high; clears all state
//  fetch_en   in   1               lookup request for addr this cycle
//  addr       in   ADDR_WIDTH      fetch byte address; held stable by the fetch stage while stall=1
//  flush      in   1               invalidate all lines (one-cycle pulse)
//  instr      out  INSTR_WIDTH     fetched instruction, valid when cache_hit=1
//  cache_hit  out  1               registered hit for the previous-cycle lookup
//  stall      out  1               miss in progress; fetch must hold addr
//  req_mem    out  1               refill request to memory
//  req_addr   out  ADDR_WIDTH-OFF_W  line address (tag,index) of the refill
//  mem_data   in   LINE_WIDTH      refill line
//  mem_rdy    in   1               mem_data valid this cycle (single-cycle pulse)
// BEHAVIOUR
//  - Reset (async):
//    - all valid bits 0, round-robin pointers 0;
//    - instr=0, cache_hit=0, stall=0, req_mem=0, req_addr=0;
//    - FSM=IDLE, pending flush cleared.
//  - The FSM has four states: IDLE, MISS, WAIT, FILL.
//  - IDLE, fetch_en=1, at a clock edge:
//    - tag-compare all ways of set addr[OFF_W+IDX_W-1:OFF_W];
//    - hit = valid & tag match; at most one way can match.
//    - Hit: the next cycle gives cache_hit=1 and instr = word addr[OFF_W-1:OFF_W-WSEL_W] of the hit line.
//      Latency is 1 cycle, throughput is 1 per cycle.
//    - Miss: go to MISS; cache_hit=0, stall=1 from the next cycle.
//  - IDLE, fetch_en=0: cache_hit=0 next cycle; instr holds its last value.
//  - MISS: drive req_mem=1 and req_addr=addr[ADDR_WIDTH-1:OFF_W]; go to WAIT.
//  - WAIT: req_mem and req_addr stay stable until mem_rdy=1.
//    - On mem_rdy: write mem_data into the victim way, set tag and valid, deassert req_mem; go to FILL.
//  - FILL: stall stays 1 and a lookup is replayed; the next cycle gives cache_hit=1 with the filled word and stall=0.
//    - Miss-to-hit latency = 3 + memory latency.
//  - Victim selection:
//    - lowest-index invalid way in the set;
//    - otherwise the set's round-robin pointer, which then increments mod NWAYS.
//    - The pointer advances only on fills that evict a valid line.
//  - mem_rdy outside WAIT is ignored.
//  - fetch_en is ignored while stall=1.
//  - Flush:
//    - in IDLE: all valid bits are cleared at the edge; a same-cycle lookup is treated as a miss.
//    - in MISS/WAIT/FILL: the flush is latched as pending; the refill completes and returns its hit.
//      All lines (including the refilled one) are invalidated on the first IDLE cycle.
//  - Reset during WAIT: req_mem drops immediately and the refill is abandoned; a later mem_rdy is ignored.
//  - NWAYS=1 degenerates to direct-mapped with no replacement pointer.
// CONFIGURATION
//  ICACHE_SA_PERF_CNT_EN:
//   - Defined: adds outputs hit_cnt[31:0] and miss_cnt[31:0].
//     - hit_cnt increments per IDLE-state hit, including the FILL replay.
//     - miss_cnt increments per IDLE-to-MISS transition.
//     - Both saturate at 32'hFFFF_FFFF and are cleared by reset, not by flush.
//   - Undefined: ports and counters are absent; all other behaviour is identical.
// TESTING
//  1. Cold miss: reset, fetch 0x0000_0040.
//     -> req_mem=1 with req_addr=0x000_0004; mem_rdy with line {D3,D2,D1,D0}.
//     -> after FILL, cache_hit=1, instr=D0; then fetch 0x44 -> hit next cycle, instr=D1.
//  2. Associativity: fetch 0x040, 0x080, 0x0C0 (all set 0, distinct tags), each filled.
//     -> 0x0C0 evicts 0x040 (RR ptr=0); a re-fetch of 0x080 hits, a re-fetch of 0x040 misses.
//  3. Back-to-back hits: 8 consecutive fetches in 2 resident lines -> cache_hit=1 every cycle, stall=0 throughout.
//  4. Flush: flush pulse in IDLE -> next fetch of a resident address misses.
//     Flush during WAIT -> refill hit is returned, then the same address misses again.
//  5. Reset mid-miss: assert reset in WAIT.
//     -> req_mem=0 and stall=0 immediately; a late mem_rdy causes no write; the next fetch misses.
//  6. With ICACHE_SA_PERF_CNT_EN: run scenario 2.
//     -> miss_cnt=4, hit_cnt=5 (3 FILL replays + 0x080 re-fetch + 0x040 replay).

Source files
------------

// File: rtl/icache_sa.sv
// icache_sa: set-associative instruction cache with round-robin replacement, miss FSM and deferred flush.
// Optional macro ICACHE_SA_PERF_CNT_EN adds saturating hit_cnt/miss_cnt outputs.
`default_nettype none

module icache_sa #(
  parameter int ADDR_WIDTH  = 32,
  parameter int INSTR_WIDTH = 32,
  parameter int LINE_WIDTH  = 128,
  parameter int NSETS       = 4,
  parameter int NWAYS       = 2
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic                                          fetch_en,
  input  logic [ADDR_WIDTH-1:0]                         addr,
  input  logic                                          flush,
  output logic [INSTR_WIDTH-1:0]                        instr,
  output logic                                          cache_hit,
  output logic                                          stall,
  output logic                                          req_mem,
  output logic [ADDR_WIDTH-$clog2(LINE_WIDTH/8)-1:0]    req_addr,
  input  logic [LINE_WIDTH-1:0]                         mem_data,
  input  logic                                          mem_rdy
`ifdef ICACHE_SA_PERF_CNT_EN
  ,
  output logic [31:0]                                   hit_cnt,
  output logic [31:0]                                   miss_cnt
`endif
);

  localparam int OFF_W  = $clog2(LINE_WIDTH/8);
  localparam int IDX_W  = $clog2(NSETS);
  localparam int TAG_W  = ADDR_WIDTH - IDX_W - OFF_W;
  localparam int WSEL_W = $clog2(LINE_WIDTH/INSTR_WIDTH);
  localparam int WS_W   = (WSEL_W > 0) ? WSEL_W : 1;
  localparam int LOW_W  = OFF_W - WSEL_W;
  localparam int WAY_W  = (NWAYS > 1) ? $clog2(NWAYS) : 1;
  localparam int LA_W   = ADDR_WIDTH - OFF_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MISS = 2'd1,
    S_WAIT = 2'd2,
    S_FILL = 2'd3
  } state_t;

  state_t r_state;
  logic   r_flush_pend;

  logic [NWAYS-1:0]      r_valid [NSETS];
  logic [TAG_W-1:0]      r_tag   [NSETS][NWAYS];
  logic [LINE_WIDTH-1:0] r_data  [NSETS][NWAYS];

  logic [IDX_W-1:0]       w_idx;
  logic [TAG_W-1:0]       w_tag;
  logic [WS_W-1:0]        w_wsel;
  logic                   w_hit;
  logic [LINE_WIDTH-1:0]  w_hit_line;
  logic [INSTR_WIDTH-1:0] w_hit_word;
  logic                   w_lookup_hit;
  logic                   w_hit_evt;
  logic                   w_miss_evt;
  logic                   w_fill;
  logic [IDX_W-1:0]       w_fidx;
  logic [TAG_W-1:0]       w_ftag;
  logic [WAY_W-1:0]       w_vict;
  logic [WAY_W-1:0]       w_rr;
  logic                   w_free;

  assign w_idx = addr[OFF_W +: IDX_W];
  assign w_tag = addr[ADDR_WIDTH-1 -: TAG_W];

  generate
    if (WSEL_W > 0) begin : g_wsel
      assign w_wsel = addr[OFF_W-WSEL_W +: WSEL_W];
    end else begin : g_nowsel
      assign w_wsel = '0;
    end
    if (LOW_W > 0) begin : g_low
      logic w_unused_low;
      assign w_unused_low = ^addr[LOW_W-1:0];
    end
  endgenerate

  always_comb begin
    w_hit      = 1'b0;
    w_hit_line = '0;
    for (int w = 0; w < NWAYS; w++) begin
      if (r_valid[w_idx][w] && (r_tag[w_idx][w] == w_tag)) begin
        w_hit      = 1'b1;
        w_hit_line = r_data[w_idx][w];
      end
    end
  end

  assign w_hit_word   = w_hit_line[w_wsel*INSTR_WIDTH +: INSTR_WIDTH];
  // A flush (live or deferred) seen in IDLE invalidates everything at this edge, so it also kills the lookup.
  assign w_lookup_hit = w_hit && !flush && !r_flush_pend;
  assign w_hit_evt    = ((r_state == S_IDLE) && fetch_en && w_lookup_hit) || (r_state == S_FILL);
  assign w_miss_evt   = (r_state == S_IDLE) && fetch_en && !w_lookup_hit;

  // The outstanding request register doubles as the refill's set/tag.
  assign w_fill = (r_state == S_WAIT) && mem_rdy;
  assign w_fidx = req_addr[IDX_W-1:0];
  assign w_ftag = req_addr[LA_W-1 -: TAG_W];

  always_comb begin
    w_vict = w_rr;
    w_free = 1'b0;
    for (int w = NWAYS-1; w >= 0; w--) begin
      if (!r_valid[w_fidx][w]) begin
        w_vict = WAY_W'(w);
        w_free = 1'b1;
      end
    end
  end

  generate
    if (NWAYS > 1) begin : g_rr
      logic [WAY_W-1:0] r_rr [NSETS];
      assign w_rr = r_rr[w_fidx];
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int s = 0; s < NSETS; s++) r_rr[s] <= '0;
        end else if (w_fill && !w_free) begin
          r_rr[w_fidx] <= r_rr[w_fidx] + 1'b1;
        end
      end
    end else begin : g_norr
      assign w_rr = '0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (w_fill) begin
      r_data[w_fidx][w_vict] <= mem_data;
      r_tag[w_fidx][w_vict]  <= w_ftag;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_flush_pend <= 1'b0;
      instr        <= '0;
      cache_hit    <= 1'b0;
      stall        <= 1'b0;
      req_mem      <= 1'b0;
      req_addr     <= '0;
      for (int s = 0; s < NSETS; s++) r_valid[s] <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (flush || r_flush_pend) begin
            for (int s = 0; s < NSETS; s++) r_valid[s] <= '0;
          end
          r_flush_pend <= 1'b0;
          if (fetch_en) begin
            if (w_lookup_hit) begin
              cache_hit <= 1'b1;
              instr     <= w_hit_word;
            end else begin
              cache_hit <= 1'b0;
              stall     <= 1'b1;
              r_state   <= S_MISS;
            end
          end else begin
            cache_hit <= 1'b0;
          end
        end
        S_MISS: begin
          r_flush_pend <= r_flush_pend | flush;
          req_mem      <= 1'b1;
          req_addr     <= addr[ADDR_WIDTH-1:OFF_W];
          r_state      <= S_WAIT;
        end
        S_WAIT: begin
          r_flush_pend <= r_flush_pend | flush;
          if (mem_rdy) begin
            r_valid[w_fidx][w_vict] <= 1'b1;
            req_mem                 <= 1'b0;
            r_state                 <= S_FILL;
          end
        end
        S_FILL: begin
          r_flush_pend <= r_flush_pend | flush;
          cache_hit    <= 1'b1;
          instr        <= w_hit_word;
          stall        <= 1'b0;
          r_state      <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef ICACHE_SA_PERF_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (w_hit_evt && (hit_cnt != 32'hFFFF_FFFF))   hit_cnt  <= hit_cnt + 32'd1;
      if (w_miss_evt && (miss_cnt != 32'hFFFF_FFFF)) miss_cnt <= miss_cnt + 32'd1;
    end
  end
`else
  logic w_unused_evt;
  assign w_unused_evt = w_hit_evt ^ w_miss_evt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_icache_sa.sv
// tb_icache_sa: directed bench for icache_sa with a transaction-level cache model and per-cycle compare.
`default_nettype none

module tb_icache_sa;

  localparam int NS = 4;
  localparam int NW = 2;

  logic         clk = 1'b0;
  logic         reset;
  logic         fetch_en;
  logic [31:0]  addr;
  logic         flush;
  logic [31:0]  instr;
  logic         cache_hit;
  logic         stall;
  logic         req_mem;
  logic [27:0]  req_addr;
  logic [127:0] mem_data;
  logic         mem_rdy;
`ifdef ICACHE_SA_PERF_CNT_EN
  logic [31:0]  hit_cnt;
  logic [31:0]  miss_cnt;
`endif

  icache_sa dut (
    .clk(clk), .reset(reset), .fetch_en(fetch_en), .addr(addr), .flush(flush),
    .instr(instr), .cache_hit(cache_hit), .stall(stall), .req_mem(req_mem),
    .req_addr(req_addr), .mem_data(mem_data), .mem_rdy(mem_rdy)
`ifdef ICACHE_SA_PERF_CNT_EN
    , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Expected outputs for the current cycle, refreshed just after each rising edge.
  bit          chk_en = 1'b0;
  logic        e_hit, e_stall, e_req;
  logic [31:0] e_instr;
  logic [27:0] e_raddr;

  task automatic set_exp(input logic h, input logic [31:0] ins, input logic st, input logic rq,
                         input logic [27:0] ra);
    e_hit = h; e_instr = ins; e_stall = st; e_req = rq; e_raddr = ra;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check32("cache_hit", {31'b0, cache_hit}, {31'b0, e_hit});
      check32("stall", {31'b0, stall}, {31'b0, e_stall});
      check32("req_mem", {31'b0, req_mem}, {31'b0, e_req});
      if (e_req) check32("req_addr", {4'b0, req_addr}, {4'b0, e_raddr});
      if (e_hit) check32("instr", instr, e_instr);
    end
  end

  // Observed miss count and last requested line, used for literal pins.
  int          n_dut_miss = 0;
  logic        prev_stall = 1'b0;
  logic [27:0] last_req = '0;
  always @(negedge clk) begin
    if (stall && !prev_stall) n_dut_miss++;
    prev_stall = stall;
    if (req_mem) last_req = req_addr;
  end

  // Cache model: per-set tags, valid flags and round-robin pointers.
  bit          m_valid [NS][NW];
  logic [25:0] m_tag   [NS][NW];
  int          m_rr    [NS];
  bit          m_pend;

  function automatic logic [31:0] mword(input logic [27:0] la, input int w);
    return 32'h5A00_0000 ^ {la, 4'(w)};
  endfunction

  function automatic logic [127:0] mline(input logic [27:0] la);
    logic [127:0] l;
    for (int w = 0; w < 4; w++) l[w*32 +: 32] = mword(la, w);
    return l;
  endfunction

  task automatic model_clear();
    for (int s = 0; s < NS; s++)
      for (int w = 0; w < NW; w++) m_valid[s][w] = 1'b0;
  endtask

  function automatic bit m_lookup(input logic [31:0] a);
    int s = int'(a[5:4]);
    for (int w = 0; w < NW; w++)
      if (m_valid[s][w] && m_tag[s][w] == a[31:6]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_fill(input logic [31:0] a);
    int s = int'(a[5:4]);
    int v = -1;
    for (int w = 0; w < NW; w++)
      if (!m_valid[s][w] && v < 0) v = w;
    if (v < 0) begin
      v = m_rr[s];
      m_rr[s] = (m_rr[s] + 1) % NW;
    end
    m_valid[s][v] = 1'b1;
    m_tag[s][v]   = a[31:6];
  endtask

  // One fetch: a hit completes in one cycle; a miss walks request, refill after lat cycles, replay.
  task automatic do_fetch(input logic [31:0] a, input int lat, input bit fl_now, input bit fl_mid);
    logic [27:0] la = a[31:4];
    bit hit;
    if (fl_now || m_pend) begin
      model_clear();
      m_pend = 1'b0;
    end
    hit = m_lookup(a);
    fetch_en = 1'b1; addr = a; flush = fl_now;
    @(posedge clk); #1;
    flush = 1'b0;
    if (hit) begin
      fetch_en = 1'b0;
      set_exp(1'b1, mword(la, int'(a[3:2])), 1'b0, 1'b0, '0);
      return;
    end
    set_exp(1'b0, '0, 1'b1, 1'b0, '0);
    @(posedge clk); #1;
    set_exp(1'b0, '0, 1'b1, 1'b1, la);
    for (int k = 1; k <= lat; k++) begin
      flush = (k == 1) && fl_mid;
      if (k == lat) begin
        mem_rdy = 1'b1;
        mem_data = mline(la);
      end
      @(posedge clk); #1;
      flush = 1'b0; mem_rdy = 1'b0; mem_data = {4{32'hDEAD_BEEF}};
      if (k < lat) set_exp(1'b0, '0, 1'b1, 1'b1, la);
      else         set_exp(1'b0, '0, 1'b1, 1'b0, '0);
    end
    if (fl_mid) m_pend = 1'b1;
    model_fill(a);
    @(posedge clk); #1;
    fetch_en = 1'b0;
    set_exp(1'b1, mword(la, int'(a[3:2])), 1'b0, 1'b0, '0);
  endtask

  task automatic idle(input int n, input bit fl, input bit spur);
    fetch_en = 1'b0; flush = fl; mem_rdy = spur;
    if (spur) mem_data = {4{32'hBAD0_BAD0}};
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if ((fl && i == 0) || m_pend) begin
        model_clear();
        m_pend = 1'b0;
      end
      flush = 1'b0; mem_rdy = 1'b0;
      set_exp(1'b0, '0, 1'b0, 1'b0, '0);
    end
  endtask

  initial begin
    reset = 1'b1; fetch_en = 1'b0; addr = '0; flush = 1'b0; mem_rdy = 1'b0; mem_data = '0;
    model_clear();
    for (int s = 0; s < NS; s++) m_rr[s] = 0;
    m_pend = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check32("rst_instr", instr, 32'h0);
    check32("rst_cache_hit", {31'b0, cache_hit}, 32'h0);
    check32("rst_stall", {31'b0, stall}, 32'h0);
    check32("rst_req_mem", {31'b0, req_mem}, 32'h0);
    check32("rst_req_addr", {4'b0, req_addr}, 32'h0);
    reset = 1'b0;
    set_exp(1'b0, '0, 1'b0, 1'b0, '0);
    chk_en = 1'b1;
    idle(1, 1'b0, 1'b0);

    // Cold miss, then a neighbouring word of the same line
    do_fetch(32'h0000_0040, 2, 1'b0, 1'b0);
    check32("s1_instr_D0", instr, 32'h5A00_0040);
    check32("s1_req_addr", {4'b0, last_req}, 32'h0000_0004);
    do_fetch(32'h0000_0044, 0, 1'b0, 1'b0);
    check32("s1_instr_D1", instr, 32'h5A00_0041);

    // Associativity and round-robin eviction in set 0
    do_fetch(32'h0000_0080, 1, 1'b0, 1'b0);
    do_fetch(32'h0000_00C0, 3, 1'b0, 1'b0);
    do_fetch(32'h0000_0080, 1, 1'b0, 1'b0);
    check32("s2_refetch_080", instr, 32'h5A00_0080);
    do_fetch(32'h0000_0040, 2, 1'b0, 1'b0);
    check32("s2_miss_count", n_dut_miss, 32'd4);
`ifdef ICACHE_SA_PERF_CNT_EN
    check32("perf_miss_cnt", miss_cnt, 32'd4);
    check32("perf_hit_cnt", hit_cnt, 32'd6);
`endif

    // Two resident lines, then eight back-to-back hits
    do_fetch(32'h0000_0100, 1, 1'b0, 1'b0);
    do_fetch(32'h0000_0110, 1, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) do_fetch(32'h0000_0100 + 32'(i*4), 1, 1'b0, 1'b0);
    check32("s3_last_word", instr, 32'h5A00_0113);

    // Stray mem_rdy while idle must not disturb resident data
    idle(2, 1'b0, 1'b1);
    do_fetch(32'h0000_0104, 1, 1'b0, 1'b0);
    check32("spur_data", instr, 32'h5A00_0101);

    // Flushes: idle pulse, same-cycle with a fetch, and deferred during a refill
    idle(1, 1'b1, 1'b0);
    do_fetch(32'h0000_0100, 1, 1'b0, 1'b0);
    do_fetch(32'h0000_0100, 1, 1'b1, 1'b0);
    do_fetch(32'h0000_0110, 3, 1'b0, 1'b1);
    check32("s4_flushed_refill", instr, 32'h5A00_0110);
    do_fetch(32'h0000_0110, 1, 1'b0, 1'b0);
    check32("s4_miss_count", n_dut_miss, 32'd10);

    // Reset in the middle of a refill wait
    fetch_en = 1'b1; addr = 32'h0000_0200;
    @(posedge clk); #1;
    set_exp(1'b0, '0, 1'b1, 1'b0, '0);
    @(posedge clk); #1;
    set_exp(1'b0, '0, 1'b1, 1'b1, 28'h20);
    @(negedge clk);
    chk_en = 1'b0;
    #2 reset = 1'b1;
    #1;
    check32("s5_req_mem_drop", {31'b0, req_mem}, 32'h0);
    check32("s5_stall_drop", {31'b0, stall}, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0; fetch_en = 1'b0;
    model_clear();
    for (int s = 0; s < NS; s++) m_rr[s] = 0;
    m_pend = 1'b0;
    mem_rdy = 1'b1; mem_data = mline(28'h20);
    set_exp(1'b0, '0, 1'b0, 1'b0, '0);
    chk_en = 1'b1;
    @(posedge clk); #1;
    mem_rdy = 1'b0;
    idle(1, 1'b0, 1'b0);
    do_fetch(32'h0000_0200, 2, 1'b0, 1'b0);
    do_fetch(32'h0000_0110, 1, 1'b0, 1'b0);
    check32("s5_miss_count", n_dut_miss, 32'd13);
    idle(2, 1'b0, 1'b0);
    chk_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
